// File: rtl/mc_cfg_apb_bridge_pkg.sv
// +--------------------------------------------------------------------------+
// | mc_cfg_pkg : shared types and widths for the APB-to-config bridge        |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package mc_cfg_pkg;

   localparam int MC_CFG_ADDR_W = 8;
   localparam int MC_CFG_DATA_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR      = 3'd1,
      ST_RD_ADDR = 3'd2,
      ST_RD_DATA = 3'd3,
      ST_RESP    = 3'd4
   } mc_cfg_state_e;

endpackage

`default_nettype wire

// File: rtl/mc_cfg_apb_bridge_if.sv
// +--------------------------------------------------------------------------+
// | mc_cfg_apb_bridge_if : APB3 host bus plus config-register side signals   |
// | Revision             : 1.0                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

interface mc_cfg_apb_bridge_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   logic [7:0]        cfg_addr;
   logic [DATA_W-1:0] cfg_wdata;
   logic              cfg_we;
   logic [DATA_W-1:0] cfg_rdata;
   logic              cfg_valid;

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, cfg_rdata, cfg_valid,
      output prdata, pready, pslverr, cfg_addr, cfg_wdata, cfg_we
   );

   modport master (
      output psel, penable, pwrite, paddr, pwdata, cfg_rdata, cfg_valid,
      input  prdata, pready, pslverr, cfg_addr, cfg_wdata, cfg_we
   );
endinterface

`default_nettype wire

// File: rtl/mc_cfg_apb_bridge_timeout.sv
// +--------------------------------------------------------------------------+
// | mc_cfg_timeout : counts cfg_valid-low cycles, flags the TIMEOUT-th one   |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module mc_cfg_timeout #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic inc_i,
   output logic expire_o
);

   localparam int                CNT_W  = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q;

   // Expires on the low cycle that would bring the tally to TIMEOUT.
   assign expire_o = inc_i && (cnt_q == C_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i && !expire_o) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/mc_cfg_apb_bridge.sv
// +--------------------------------------------------------------------------+
// | mc_cfg_apb_bridge : APB3 slave translating host accesses into single     |
// | config-register accesses. Revision : 1.0                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module mc_cfg_apb_bridge
   import mc_cfg_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = MC_CFG_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               reset,
   mc_cfg_apb_bridge_if.slave bus,
   output logic [7:0]         err_count
);

   mc_cfg_state_e              state_q;
   logic                       err_q;
   logic [DATA_W-1:0]          prdata_q;
   logic [MC_CFG_ADDR_W-1:0]   cfg_addr_q;
   logic [DATA_W-1:0]          cfg_wdata_q;
   logic [7:0]                 err_count_q;
   logic [7:0]                 err_count_d;

   logic                       w_setup;
   logic                       w_wr_ok;
   logic                       w_wait;
   logic                       w_expire;
   logic                       w_pready;
   logic                       w_pslverr;

   assign w_setup   = (state_q == ST_IDLE) && bus.psel && !bus.penable;
   assign w_wr_ok   = (state_q == ST_WR) && bus.cfg_valid;
   assign w_wait    = ((state_q == ST_WR) || (state_q == ST_RD_DATA)) && !bus.cfg_valid;
   assign w_pready  = w_wr_ok || (state_q == ST_RESP);
   assign w_pslverr = (state_q == ST_RESP) && err_q;

   assign bus.pready    = w_pready;
   assign bus.pslverr   = w_pslverr;
   assign bus.cfg_we    = w_wr_ok;
   assign bus.prdata    = prdata_q;
   assign bus.cfg_addr  = cfg_addr_q;
   assign bus.cfg_wdata = cfg_wdata_q;
   assign err_count     = err_count_q;

   mc_cfg_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (w_setup),
      .inc_i    (w_wait),
      .expire_o (w_expire)
   );

   always_comb begin
      err_count_d = err_count_q;
      if (w_pready && w_pslverr && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         err_q       <= 1'b0;
         prdata_q    <= '0;
         cfg_addr_q  <= '0;
         cfg_wdata_q <= '0;
         err_count_q <= '0;
      end else begin
         err_count_q <= err_count_d;
         case (state_q)
            ST_IDLE: begin
               if (w_setup) begin
                  cfg_addr_q  <= bus.paddr[ADDR_W-1:2];
                  cfg_wdata_q <= bus.pwdata;
                  if (bus.paddr[1:0] != 2'b00) begin
                     err_q   <= 1'b1;
                     state_q <= ST_RESP;
                  end else begin
                     err_q   <= 1'b0;
                     state_q <= bus.pwrite ? ST_WR : ST_RD_ADDR;
                  end
               end
            end
            ST_WR: begin
               // A valid on the last counted cycle completes the write.
               if (bus.cfg_valid) begin
                  state_q <= ST_IDLE;
               end else if (w_expire) begin
                  err_q   <= 1'b1;
                  state_q <= ST_RESP;
               end
            end
            ST_RD_ADDR: begin
               state_q <= ST_RD_DATA;
            end
            ST_RD_DATA: begin
               if (bus.cfg_valid) begin
                  prdata_q <= bus.cfg_rdata;
                  err_q    <= 1'b0;
                  state_q  <= ST_RESP;
               end else if (w_expire) begin
                  prdata_q <= '0;
                  err_q    <= 1'b1;
                  state_q  <= ST_RESP;
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mc_cfg_apb_bridge.sv
// +--------------------------------------------------------------------------+
// | tb_mc_cfg_apb_bridge : scoreboard bench with a config-block model        |
// | Revision             : 1.0                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mc_cfg_apb_bridge;

   localparam int TIMEOUT = 16;
   localparam int BUDGET  = TIMEOUT + 10;
   localparam int NEVER   = 1000;

   typedef struct {
      int          exp_cyc;
      bit          is_rd;
      bit          err;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic [7:0]  idx;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  err_count;
   logic        cfg_load = 1'b0;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   int          err_model = 0;

   logic [31:0] ref_mem [256];
   logic [31:0] cfg_mem [256];
   exp_t        exp_q [$];
   wr_t         wr_q [$];

   mc_cfg_apb_bridge_if #(.ADDR_W(10), .DATA_W(32)) bus ();

   mc_cfg_apb_bridge #(
      .ADDR_W  (10),
      .DATA_W  (32),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Config register block: registered read, one cycle after the address.
   always @(posedge clk) begin
      if (cfg_load) begin
         for (int i = 0; i < 256; i++) cfg_mem[i] <= ref_mem[i];
      end else if (bus.cfg_we) begin
         cfg_mem[bus.cfg_addr] <= bus.cfg_wdata;
      end
      bus.cfg_rdata <= cfg_mem[bus.cfg_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every DUT response against the scoreboard head.
   always @(negedge clk) begin
      if (reset) begin
         if (bus.pready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pready", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("latency", 32'(cyc), 32'(e.exp_cyc));
               chk("pslverr", {31'd0, bus.pslverr}, {31'd0, e.err});
               if (e.is_rd) chk("prdata", bus.prdata, e.data);
            end
         end
         if (bus.cfg_we) begin
            if (wr_q.size() == 0) begin
               chk("unexpected_cfg_we", 32'd1, 32'd0);
            end else begin
               wr_t w;
               w = wr_q.pop_front();
               chk("cfg_addr", {24'd0, bus.cfg_addr}, {24'd0, w.idx});
               chk("cfg_wdata", bus.cfg_wdata, w.data);
            end
         end
      end
   end

   // Reference model: outcome of one transfer from the access rules.
   task automatic predict(input bit wr, input logic [9:0] addr, input logic [31:0] data,
                          input int valid_at, input int setup);
      exp_t e;
      wr_t  w;
      int   first;
      e.is_rd = 1'b0;
      e.data  = '0;
      if (addr[1:0] != 2'b00) begin
         e.err     = 1'b1;
         e.exp_cyc = setup + 1;
      end else if (wr) begin
         first = (valid_at > 1) ? valid_at : 1;
         if (first <= TIMEOUT) begin
            e.err     = 1'b0;
            e.exp_cyc = setup + first;
            ref_mem[addr[9:2]] = data;
            w.idx  = addr[9:2];
            w.data = data;
            wr_q.push_back(w);
         end else begin
            e.err     = 1'b1;
            e.exp_cyc = setup + TIMEOUT + 1;
         end
      end else begin
         e.is_rd = 1'b1;
         first = (valid_at > 2) ? valid_at : 2;
         if (first <= TIMEOUT + 1) begin
            e.err     = 1'b0;
            e.exp_cyc = setup + first + 1;
            e.data    = ref_mem[addr[9:2]];
         end else begin
            e.err     = 1'b1;
            e.exp_cyc = setup + TIMEOUT + 2;
         end
      end
      if (e.err && err_model < 255) err_model++;
      exp_q.push_back(e);
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after pready.
   task automatic xfer(input bit wr, input logic [9:0] addr, input logic [31:0] data,
                       input int valid_at);
      int n;
      bit done;
      bus.psel      = 1'b1;
      bus.penable   = 1'b0;
      bus.pwrite    = wr;
      bus.paddr     = addr;
      bus.pwdata    = data;
      bus.cfg_valid = (valid_at <= 0);
      predict(wr, addr, data, valid_at, cyc);
      n = 0;
      done = 1'b0;
      while (!done && n < BUDGET) begin
         @(negedge clk);
         if (bus.pready) done = 1'b1;
         @(posedge clk);
         #1;
         n++;
         bus.penable   = 1'b1;
         bus.cfg_valid = (n >= valid_at);
      end
      if (!done) chk("pready_budget", 32'd0, 32'd1);
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.psel      = 1'b0;
      bus.penable   = 1'b0;
      bus.pwrite    = 1'b0;
      bus.paddr     = '0;
      bus.pwdata    = '0;
      bus.cfg_valid = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
      ref_mem[0] = 32'd3200;
      ref_mem[1] = 32'd64;
      cfg_load = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      cfg_load = 1'b0;
      reset    = 1'b1;

      chk("rst_prdata",    bus.prdata, 32'd0);
      chk("rst_pready",    {31'd0, bus.pready}, 32'd0);
      chk("rst_pslverr",   {31'd0, bus.pslverr}, 32'd0);
      chk("rst_cfg_we",    {31'd0, bus.cfg_we}, 32'd0);
      chk("rst_cfg_addr",  {24'd0, bus.cfg_addr}, 32'd0);
      chk("rst_cfg_wdata", bus.cfg_wdata, 32'd0);
      chk("rst_err_count", {24'd0, err_count}, 32'd0);

      xfer(1'b1, 10'h010, 32'hDEADBEEF, 0);
      xfer(1'b0, 10'h000, 32'h0, 0);
      xfer(1'b0, 10'h004, 32'h0, 0);
      xfer(1'b0, 10'h010, 32'h0, 0);
      xfer(1'b0, 10'h006, 32'h0, 0);
      chk("err_count_misaligned", {24'd0, err_count}, 32'd1);

      xfer(1'b1, 10'h020, 32'h12345678, NEVER);
      xfer(1'b0, 10'h020, 32'h0, NEVER);
      xfer(1'b0, 10'h000, 32'h0, 10);
      xfer(1'b1, 10'h024, 32'hA5A5F00D, TIMEOUT);
      xfer(1'b1, 10'h028, 32'h0BADCAFE, TIMEOUT + 1);
      xfer(1'b0, 10'h024, 32'h0, TIMEOUT + 1);
      xfer(1'b0, 10'h028, 32'h0, TIMEOUT + 2);
      chk("err_count_timeouts", {24'd0, err_count}, 32'(err_model));

      // Abort a read during its data-wait cycle.
      bus.psel    = 1'b1;
      bus.penable = 1'b0;
      bus.pwrite  = 1'b0;
      bus.paddr   = 10'h004;
      @(posedge clk); #1;
      bus.penable = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("abort_pready",    {31'd0, bus.pready}, 32'd0);
      chk("abort_pslverr",   {31'd0, bus.pslverr}, 32'd0);
      chk("abort_cfg_we",    {31'd0, bus.cfg_we}, 32'd0);
      chk("abort_prdata",    bus.prdata, 32'd0);
      chk("abort_cfg_addr",  {24'd0, bus.cfg_addr}, 32'd0);
      chk("abort_cfg_wdata", bus.cfg_wdata, 32'd0);
      chk("abort_err_count", {24'd0, err_count}, 32'd0);
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      err_model   = 0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      xfer(1'b0, 10'h004, 32'h0, 0);

      for (int k = 0; k < 60; k++) begin
         bit          wr;
         logic [7:0]  idx;
         logic [1:0]  mis;
         int          r;
         int          va;
         wr  = 1'($urandom_range(0, 1));
         idx = 8'($urandom_range(0, 15));
         mis = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         r   = int'($urandom_range(0, 9));
         va  = (r < 7) ? 0 : (r < 9) ? int'($urandom_range(1, TIMEOUT + 2)) : NEVER;
         xfer(wr, {idx, mis}, $urandom, va);
      end
      chk("err_count_random", {24'd0, err_count}, 32'(err_model));

      for (int k = 0; k < 300; k++) xfer(1'b0, 10'h006, 32'h0, 0);
      chk("err_count_saturated", {24'd0, err_count}, 32'd255);
      chk("err_count_model", {24'd0, err_count}, 32'(err_model));

      repeat (2) @(negedge clk);
      chk("resp_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("write_queue_empty", 32'(wr_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
